// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream bundle used between a packet source and its sink.
// The master modport drives the payload; the slave modport returns tready.
interface axis_pkt_gen_if #(
  parameter int TDATA_BYTES = 4,
  parameter int TID_BITS    = 1,
  parameter int TDEST_BITS  = 1,
  parameter int TUSER_BITS  = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic                     tlast;
  logic [TID_BITS-1:0]      tid;
  logic [TDEST_BITS-1:0]    tdest;
  logic [TUSER_BITS-1:0]    tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: one start pulse emits cfg_len beats of seed+k.
// Define AXIS_PKT_GEN_THROTTLE_EN to add cfg_gap idle cycles between beats.
module axis_pkt_gen #(
  parameter int TDATA_BYTES = 4,
  parameter int TID_BITS    = 1,
  parameter int TDEST_BITS  = 1,
  parameter int TUSER_BITS  = 1,
  parameter int LEN_BITS    = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               start,
  input  logic [LEN_BITS-1:0]                cfg_len,
  input  logic [$clog2(TDATA_BYTES+1)-1:0]   cfg_tail,
  input  logic [TDATA_BYTES*8-1:0]           cfg_seed,
  input  logic [TID_BITS-1:0]                cfg_id,
  input  logic [TDEST_BITS-1:0]              cfg_dest,
`ifdef AXIS_PKT_GEN_THROTTLE_EN
  input  logic [7:0]                         cfg_gap,
`endif
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  axis_pkt_gen_if.master                     m
);

  localparam int DW = TDATA_BYTES * 8;
  localparam int TW = $clog2(TDATA_BYTES + 1);

`ifdef AXIS_PKT_GEN_THROTTLE_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t                 state_q, state_d;
  logic [LEN_BITS-1:0]    cnt_q, cnt_d, len_q, len_d;
  logic [TW-1:0]          tail_q, tail_d;
  logic [TID_BITS-1:0]    id_q, id_d;
  logic [TDEST_BITS-1:0]  dest_q, dest_d;
  logic                   tvalid_q, tvalid_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic [TDATA_BYTES-1:0] keep_q, keep_d;
  logic                   tlast_q, tlast_d;
  logic                   tuser0_q, tuser0_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
  logic [7:0]             gap_q, gap_d, gcnt_q, gcnt_d;
`endif

  logic accept, xfer, next_last;

  function automatic logic [TDATA_BYTES-1:0] tail_mask(input logic [TW-1:0] t);
    logic [TDATA_BYTES-1:0] msk;
    for (int unsigned b = 0; b < TDATA_BYTES; b++) msk[b] = (t == '0) || (b < 32'(t));
    return msk;
  endfunction

  assign accept    = (state_q == IDLE) && start && (cfg_len != '0);
  assign xfer      = (state_q == SEND) && m.tready;
  // Beat about to be presented is the last one when cnt+1 == len-1.
  assign next_last = ({1'b0, cnt_q} + (LEN_BITS+1)'(2)) == {1'b0, len_q};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      tail_q   <= '0;
      id_q     <= '0;
      dest_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      keep_q   <= '0;
      tlast_q  <= 1'b0;
      tuser0_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
      gap_q    <= '0;
      gcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      tail_q   <= tail_d;
      id_q     <= id_d;
      dest_q   <= dest_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      keep_q   <= keep_d;
      tlast_q  <= tlast_d;
      tuser0_q <= tuser0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: begin
        if (xfer) begin
          if (tlast_q) state_d = IDLE;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
          else if (gap_q != '0) state_d = GAP;
`endif
        end
      end
`ifdef AXIS_PKT_GEN_THROTTLE_EN
      GAP:  if (gcnt_q <= 8'd1) state_d = SEND;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    len_d    = len_q;
    tail_d   = tail_q;
    id_d     = id_q;
    dest_d   = dest_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    keep_d   = keep_q;
    tlast_d  = tlast_q;
    tuser0_d = tuser0_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          len_d    = cfg_len;
          tail_d   = cfg_tail;
          id_d     = cfg_id;
          dest_d   = cfg_dest;
          tvalid_d = 1'b1;
          tdata_d  = cfg_seed;
          tuser0_d = 1'b1;
          tlast_d  = (cfg_len == LEN_BITS'(1));
          keep_d   = (cfg_len == LEN_BITS'(1)) ? tail_mask(cfg_tail) : '1;
          busy_d   = 1'b1;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
          gap_d    = cfg_gap;
`endif
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            keep_d   = '0;
            tlast_d  = 1'b0;
            tuser0_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            cnt_d    = cnt_q + LEN_BITS'(1);
            tdata_d  = tdata_q + DW'(1);
            tuser0_d = 1'b0;
            tlast_d  = next_last;
            keep_d   = next_last ? tail_mask(tail_q) : '1;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
            // Next beat is staged now; tvalid stays low while the gap drains.
            if (gap_q != '0) begin
              tvalid_d = 1'b0;
              gcnt_d   = gap_q;
            end
`endif
          end
        end
      end
`ifdef AXIS_PKT_GEN_THROTTLE_EN
      GAP: begin
        if (gcnt_q <= 8'd1) tvalid_d = 1'b1;
        else                gcnt_d   = gcnt_q - 8'd1;
      end
`endif
      default: ;
    endcase
  end

  assign m.tvalid = tvalid_q;
  assign m.tdata  = tdata_q;
  assign m.tkeep  = keep_q;
  assign m.tstrb  = keep_q;
  assign m.tlast  = tlast_q;
  assign m.tid    = id_q;
  assign m.tdest  = dest_q;
  assign m.tuser  = TUSER_BITS'(tuser0_q);
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: queue-based beat model plus directed timing checks.
module tb_axis_pkt_gen;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [2:0]  cfg_tail = '0;
  logic [31:0] cfg_seed = '0;
  logic        cfg_id = 1'b0;
  logic        cfg_dest = 1'b0;
`ifdef AXIS_PKT_GEN_THROTTLE_EN
  logic [7:0]  cfg_gap = '0;
`endif
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        user;
    logic        id;
    logic        dest;
  } beat_t;

  beat_t exp_q[$];

  axis_pkt_gen_if #(.TDATA_BYTES(4), .TID_BITS(1), .TDEST_BITS(1), .TUSER_BITS(1)) axis ();

  axis_pkt_gen #(
    .TDATA_BYTES(4), .TID_BITS(1), .TDEST_BITS(1), .TUSER_BITS(1), .LEN_BITS(16)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_tail (cfg_tail),
    .cfg_seed (cfg_seed),
    .cfg_id   (cfg_id),
    .cfg_dest (cfg_dest),
`ifdef AXIS_PKT_GEN_THROTTLE_EN
    .cfg_gap  (cfg_gap),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .m        (axis)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] kmask(input logic [2:0] t);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = (t == 3'd0) || (b < int'(t));
    return r;
  endfunction

  function automatic int rel();
    return cyc - t0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Caller sits 1 time unit after a rising edge; that cycle becomes cycle 0.
  task automatic send(input int len, input logic [2:0] tail, input logic [31:0] seed,
                      input logic id, input logic dest, input bit model);
    beat_t b;
    if (model) begin
      for (int k = 0; k < len; k++) begin
        b.data = seed + 32'(k);
        b.last = (k == len - 1);
        b.keep = b.last ? kmask(tail) : 4'hF;
        b.strb = b.keep;
        b.user = (k == 0);
        b.id   = id;
        b.dest = dest;
        exp_q.push_back(b);
      end
    end
    start    = 1'b1;
    cfg_len  = 16'(len);
    cfg_tail = tail;
    cfg_seed = seed;
    cfg_id   = id;
    cfg_dest = dest;
    t0       = cyc;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_cycle);
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    if (!done) chk({nm, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk(nm, 64'(rel()), 64'(exp_cycle));
      chk({nm, "_idle"}, 64'({busy, axis.tvalid}), 64'd0);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({axis.tvalid, axis.tdata, axis.tkeep, axis.tstrb, axis.tlast,
                axis.tid, axis.tdest, axis.tuser, busy, done, err});
  endfunction

  // Every presented beat must match the head of the model; a handshake retires it.
  always @(negedge aclk) begin
    beat_t a;
    if (!areset && axis.tvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data 0x%0h expected no beat", axis.tdata);
      end else begin
        a.data = axis.tdata;
        a.last = axis.tlast;
        a.keep = axis.tkeep;
        a.strb = axis.tstrb;
        a.user = axis.tuser[0];
        a.id   = axis.tid;
        a.dest = axis.tdest;
        if (a !== exp_q[0]) begin
          errors++;
          $display("FAIL beat_model: got 0x%0h expected 0x%0h", a, exp_q[0]);
        end
        if (axis.tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    axis.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    areset = 1'b0;
    step();
    chk("idle_outputs", all_outs(), 64'd0);

    // Basic packet
    send(4, 3'd0, 32'h10, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("basic_data", 64'(axis.tdata), 64'(32'h10 + 32'(k)));
      chk("basic_flags", 64'({axis.tvalid, busy, axis.tlast, axis.tuser[0]}),
          64'({1'b1, 1'b1, k == 3, k == 0}));
      step();
    end
    wait_done("basic_done", 5);
    chk("done_pulse", 64'(done), 64'd1);
    step();
    chk("done_clear", 64'(done), 64'd0);

    // Backpressure
    axis.tready = 1'b0;
    send(3, 3'd0, 32'h2000_0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", 64'({axis.tvalid, axis.tdata, axis.tuser[0]}), 64'({1'b1, 32'h2000_0000, 1'b1}));
      step();
    end
    axis.tready = 1'b1;
    chk("bp_hold4", 64'(axis.tdata), 64'h2000_0000);
    wait_done("bp_done", 7);
    step();

    // Tail, wrap, single beat
    send(1, 3'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    chk("single_beat", 64'({axis.tdata, axis.tkeep, axis.tstrb, axis.tlast, axis.tuser[0]}),
        64'({32'hFFFF_FFFF, 4'b0111, 4'b0111, 1'b1, 1'b1}));
    wait_done("single_done", 2);
    step();
    send(2, 3'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    step();
    chk("wrap_beat", 64'({axis.tdata, axis.tkeep, axis.tlast}), 64'({32'h0, 4'b0111, 1'b1}));
    wait_done("wrap_done", 3);
    step();

    // Zero length
    send(0, 3'd0, 32'h55, 1'b0, 1'b0, 1'b0);
    chk("zero_err", 64'({err, axis.tvalid, busy}), 64'b100);
    step();
    chk("zero_err_clear", 64'({err, axis.tvalid, busy}), 64'd0);
    step();

    // Start during SEND ignored, then start in the done cycle
    send(3, 3'd0, 32'h300, 1'b0, 1'b0, 1'b1);
    step();
    start = 1'b1; cfg_len = 16'd7; cfg_seed = 32'hDEAD;
    step();
    start = 1'b0;
    wait_done("ign_done", 4);
    send(2, 3'd0, 32'h400, 1'b1, 1'b1, 1'b1);
    chk("b2b_start", 64'({axis.tvalid, axis.tdata}), 64'({1'b1, 32'h400}));
    wait_done("b2b_done", 3);
    step();

    // Reset mid-packet
    send(5, 3'd0, 32'h100, 1'b0, 1'b1, 1'b1);
    step();
    step();
    chk("rst_beat2", 64'(axis.tdata), 64'h102);
    #2 areset = 1'b1;
    #1 chk("rst_async", all_outs(), 64'd0);
    exp_q.delete();
    step();
    chk("rst_held", all_outs(), 64'd0);
    areset = 1'b0;
    step();
    send(5, 3'd0, 32'h100, 1'b0, 1'b1, 1'b1);
    chk("rst_restart", 64'({axis.tvalid, axis.tdata, axis.tuser[0]}), 64'({1'b1, 32'h100, 1'b1}));
    wait_done("rst_pkt_done", 6);
    step();

`ifdef AXIS_PKT_GEN_THROTTLE_EN
    cfg_gap = 8'd2;
    send(3, 3'd0, 32'h500, 1'b0, 1'b0, 1'b1);
    cfg_gap = 8'd0;
    for (int c = 1; c <= 7; c++) begin
      chk("gap_valid", 64'(axis.tvalid), 64'((c == 1) || (c == 4) || (c == 7)));
      step();
    end
    wait_done("gap_done", 8);
    step();
`endif

    chk("model_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
